// File: rtl/mlp_seq_engine_pkg.sv
// Shared types and sizing helpers for the sequenced two-layer perceptron.
// Contents: FSM state enum, hidden/output accumulator widths, index widths,
// and the base address of the layer-2 weights in the flat weight file.
package mlp_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_L1   = 2'd1,
      S_L2   = 2'd2,
      S_DONE = 2'd3
   } state_e;

   // Hidden accumulator width: product width plus growth over N_IN terms.
   function automatic int unsigned hid_w(input int unsigned iw, input int unsigned ww,
                                         input int unsigned n_in);
      return iw + ww + $clog2(n_in);
   endfunction

   // Output accumulator width: hidden width times weight, grown over N_HID terms.
   function automatic int unsigned out_w(input int unsigned iw, input int unsigned ww,
                                         input int unsigned n_in, input int unsigned n_hid);
      return hid_w(iw, ww, n_in) + ww + $clog2(n_hid);
   endfunction

   // First layer-2 weight address; layer-1 weights occupy [0, base).
   function automatic int unsigned l2_base(input int unsigned n_in, input int unsigned n_hid);
      return n_in * n_hid;
   endfunction

   // Index width that never collapses to zero bits.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mlp_seq_engine_if.sv
// Handshake and weight-write bus of mlp_seq_engine.
// master: feature source / weight loader / result consumer side.
// slave : engine side.
//   x, in_valid -> / in_ready <-      input vector handshake
//   y, out_valid <- / out_ready ->    result handshake
//   wr_en, wr_addr, wr_data ->        weight write port
//   wr_err <-                         dropped-write pulse
interface mlp_seq_engine_if #(
   parameter int unsigned N_IN  = 4,
   parameter int unsigned N_HID = 4,
   parameter int unsigned N_OUT = 2,
   parameter int unsigned IW    = 7,
   parameter int unsigned WW    = 5
) ();

   localparam int unsigned OW = mlp_pkg::out_w(IW, WW, N_IN, N_HID);
   localparam int unsigned NW = N_IN * N_HID + N_HID * N_OUT;
   localparam int unsigned AW = $clog2(NW);

   logic [N_IN*IW-1:0]  x;
   logic                in_valid;
   logic                in_ready;
   logic [N_OUT*OW-1:0] y;
   logic                out_valid;
   logic                out_ready;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [WW-1:0]       wr_data;
   logic                wr_err;

   modport master (
      output x, in_valid, out_ready, wr_en, wr_addr, wr_data,
      input  in_ready, y, out_valid, wr_err
   );

   modport slave (
      input  x, in_valid, out_ready, wr_en, wr_addr, wr_data,
      output in_ready, y, out_valid, wr_err
   );

endinterface

// File: rtl/mlp_seq_engine_mac_lane.sv
// Signed multiply-accumulate lane.
// Ports: clk, rst (async, active-high), clr (zero accumulator), en (accumulate
// a*b), a/b signed operands, acc_nxt_c = value the accumulator takes at the
// next edge. With clr=en=0 it equals the stored accumulator, so it doubles as
// the read port.
module mlp_mac_lane #(
   parameter int unsigned AW   = 7,
   parameter int unsigned BW   = 5,
   parameter int unsigned ACCW = 14
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   en,
   input  logic signed [AW-1:0]   a,
   input  logic signed [BW-1:0]   b,
   output logic signed [ACCW-1:0] acc_nxt_c
);

   localparam int unsigned PW = AW + BW;

   logic signed [PW-1:0]   prod_c;
   logic signed [ACCW-1:0] acc_q;

   assign prod_c = PW'(a) * PW'(b);

   // Next accumulator value; clear has priority over accumulate.
   always_comb begin
      acc_nxt_c = acc_q;
      if (clr)
         acc_nxt_c = '0;
      else if (en)
         acc_nxt_c = acc_q + ACCW'(prod_c);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         acc_q <= '0;
      else
         acc_q <= acc_nxt_c;
   end

endmodule

// File: rtl/mlp_seq_engine.sv
// Time-multiplexed two-layer perceptron: dense N_IN->N_HID, optional ReLU,
// dense N_HID->N_OUT, with runtime-loadable weights.
// Ports: clk, rst (async, active-high), bus (mlp_seq_engine_if.slave) carrying
// the input handshake (x/in_valid/in_ready), the result handshake
// (y/out_valid/out_ready) and the weight write port (wr_en/wr_addr/wr_data,
// wr_err).
module mlp_seq_engine
   import mlp_pkg::*;
#(
   parameter int unsigned N_IN    = 4,
   parameter int unsigned N_HID   = 4,
   parameter int unsigned N_OUT   = 2,
   parameter int unsigned IW      = 7,
   parameter int unsigned WW      = 5,
   parameter bit          RELU_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   mlp_seq_engine_if.slave  bus
);

   localparam int unsigned HW  = hid_w(IW, WW, N_IN);
   localparam int unsigned OW  = out_w(IW, WW, N_IN, N_HID);
   localparam int unsigned NW  = N_IN * N_HID + N_HID * N_OUT;
   localparam int unsigned AW  = $clog2(NW);
   localparam int unsigned L2B = l2_base(N_IN, N_HID);
   localparam int unsigned CW  = idx_w((N_IN > N_HID) ? N_IN : N_HID);
   localparam int unsigned XIW = idx_w(N_IN);
   localparam int unsigned HIW = idx_w(N_HID);
   localparam int unsigned WIW = idx_w(NW);

   state_e                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   x_ld, acc_clr, l1_en, l2_en, y_ld;

   logic signed [IW-1:0]   x_q [N_IN];
   logic signed [WW-1:0]   w_q [NW];
   logic signed [HW-1:0]   acc1_c [N_HID];
   logic signed [OW-1:0]   acc2_c [N_OUT];
   logic signed [IW-1:0]   x_cur_c;
   logic signed [HW-1:0]   h_cur_c, h_act_c;

   logic [N_OUT*OW-1:0]    y_q;
   logic                   in_ready_q, out_valid_q, wr_err_q;
   logic                   wr_hit_c;

   // In-range write; out-of-range addresses never raise wr_err.
   assign wr_hit_c = bus.wr_en && ({1'b0, bus.wr_addr} < (AW+1)'(NW));

   assign x_cur_c = x_q[XIW'(cnt_q)];
   assign h_cur_c = acc1_c[HIW'(cnt_q)];
   assign h_act_c = (RELU_EN && h_cur_c[HW-1]) ? '0 : h_cur_c;

   // State and counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and datapath control.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_ld    = 1'b0;
      acc_clr = 1'b0;
      l1_en   = 1'b0;
      l2_en   = 1'b0;
      y_ld    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               x_ld    = 1'b1;
               acc_clr = 1'b1;
               cnt_d   = '0;
               state_d = S_L1;
            end
         end
         S_L1: begin
            l1_en = 1'b1;
            if (cnt_q == CW'(N_IN - 1)) begin
               cnt_d   = '0;
               state_d = S_L2;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_L2: begin
            l2_en = 1'b1;
            if (cnt_q == CW'(N_HID - 1)) begin
               y_ld    = 1'b1;
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            if (bus.out_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Layer 1: lane j accumulates x[cnt] * w1[cnt][j].
   for (genvar j = 0; j < N_HID; j++) begin : g_l1
      logic [WIW-1:0] w_idx_c;
      assign w_idx_c = WIW'(cnt_q) * WIW'(N_HID) + WIW'(j);
      mlp_mac_lane #(.AW(IW), .BW(WW), .ACCW(HW)) u_lane (
         .clk       (clk),
         .rst       (rst),
         .clr       (acc_clr),
         .en        (l1_en),
         .a         (x_cur_c),
         .b         (w_q[w_idx_c]),
         .acc_nxt_c (acc1_c[j])
      );
   end

   // Layer 2: lane o accumulates act(h[cnt]) * w2[cnt][o].
   for (genvar o = 0; o < N_OUT; o++) begin : g_l2
      logic [WIW-1:0] w_idx_c;
      assign w_idx_c = WIW'(L2B) + WIW'(cnt_q) * WIW'(N_OUT) + WIW'(o);
      mlp_mac_lane #(.AW(HW), .BW(WW), .ACCW(OW)) u_lane (
         .clk       (clk),
         .rst       (rst),
         .clr       (acc_clr),
         .en        (l2_en),
         .a         (h_act_c),
         .b         (w_q[w_idx_c]),
         .acc_nxt_c (acc2_c[o])
      );
   end

   // Weight file: writable only while idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NW; i++)
            w_q[i] <= '0;
      end else if (state_q == S_IDLE && wr_hit_c) begin
         w_q[WIW'(bus.wr_addr)] <= bus.wr_data;
      end
   end

   // Input latch, result register and registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_IN; i++)
            x_q[i] <= '0;
         y_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         wr_err_q    <= 1'b0;
      end else begin
         if (x_ld) begin
            for (int i = 0; i < N_IN; i++)
               x_q[i] <= bus.x[i*IW +: IW];
         end
         // acc2_c already includes the last product on the final L2 cycle.
         if (y_ld) begin
            for (int o = 0; o < N_OUT; o++)
               y_q[o*OW +: OW] <= acc2_c[o];
         end
         in_ready_q  <= (state_d == S_IDLE);
         out_valid_q <= (state_d == S_DONE);
         wr_err_q    <= wr_hit_c && (state_q != S_IDLE);
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.y         = y_q;
   assign bus.wr_err    = wr_err_q;

endmodule
